// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches between fetch and execute.
// Resolves oldest-first, flags mispredicts, and drives the branch history table update.
module branch_resolve_queue #(
  parameter int LOWER = 7,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push_valid,
  input  logic [LOWER-1:0] push_pc,
  input  logic             push_pred,
  output logic             push_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic             resolve_jump,
  output logic             bht_en,
  output logic [LOWER-1:0] bht_write_addr,
  output logic             bht_was_taken,
  output logic             bht_jumped,
  output logic             mispredict,
  output logic             redirect_taken,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [LOWER:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_q, count_next;
  logic             empty, full, pop, actual, miss, push_ok;
  logic [LOWER-1:0] head_pc;
  logic             head_pred;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_COUNT);
    head_pc    = mem[rd_ptr][LOWER:1];
    head_pred  = mem[rd_ptr][0];
    pop        = resolve_valid & ~empty;
    actual     = resolve_taken | resolve_jump;
    miss       = pop & (actual != head_pred);
    // A pop frees a slot this cycle, but a flush discards the wrong-path push.
    push_ok    = push_valid & (~full | pop) & ~miss;
    count_next = count_q;
    if (miss) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
  end

  assign push_ready = ~full;
  assign count      = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_pc, push_pred};
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      bht_en         <= 1'b0;
      bht_write_addr <= '0;
      bht_was_taken  <= 1'b0;
      bht_jumped     <= 1'b0;
      mispredict     <= 1'b0;
      redirect_taken <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      bht_en         <= pop;
      mispredict     <= miss;
      redirect_taken <= miss & actual;
      if (pop) begin
        bht_write_addr <= head_pc;
        bht_was_taken  <= resolve_taken;
        bht_jumped     <= resolve_jump;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // Flush leaves the queue empty just past the popped head.
      if (miss) begin
        wr_ptr <= rd_ptr + 1'b1;
      end else if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      count_q <= count_next;
      if (push_valid & full & ~pop) begin
        overflow <= 1'b1;
      end
      if (resolve_valid & empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: stimulus pushes expected updates,
// a negedge monitor pops and compares them whenever bht_en is presented.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       push_valid, push_pred, push_ready;
  logic [6:0] push_pc;
  logic       resolve_valid, resolve_taken, resolve_jump;
  logic       bht_en, bht_was_taken, bht_jumped, mispredict, redirect_taken;
  logic [6:0] bht_write_addr;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] addr;
    logic       taken;
    logic       jump;
    logic       mis;
    logic       redir;
  } exp_t;

  exp_t sb[$];

  branch_resolve_queue #(.LOWER(7), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .arst_n(arst_n),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_jump(resolve_jump),
    .bht_en(bht_en), .bht_write_addr(bht_write_addr), .bht_was_taken(bht_was_taken),
    .bht_jumped(bht_jumped), .mispredict(mispredict), .redirect_taken(redirect_taken),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bht_en) begin
      if (sb.size() == 0) begin
        check("unexpected_bht_en", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bht_write_addr", int'(bht_write_addr), int'(e.addr));
        check("bht_was_taken", int'(bht_was_taken), int'(e.taken));
        check("bht_jumped", int'(bht_jumped), int'(e.jump));
        check("mispredict", int'(mispredict), int'(e.mis));
        if (e.mis) check("redirect_taken", int'(redirect_taken), int'(e.redir));
      end
    end else if (mispredict) begin
      check("mispredict_without_bht_en", 1, 0);
    end
  end

  task automatic step(input logic pv, input logic [6:0] pc, input logic pp,
                      input logic rv, input logic rt, input logic rj);
    push_valid    = pv;
    push_pc       = pc;
    push_pred     = pp;
    resolve_valid = rv;
    resolve_taken = rt;
    resolve_jump  = rj;
    @(posedge clk);
    #1;
    push_valid    = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    resolve_jump  = 1'b0;
  endtask

  task automatic push(input logic [6:0] pc, input logic pred);
    step(1'b1, pc, pred, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_upd(input logic [6:0] addr, input logic rt, input logic rj, input logic mis);
    exp_t e;
    e.addr = addr; e.taken = rt; e.jump = rj; e.mis = mis; e.redir = rt | rj;
    sb.push_back(e);
  endtask

  task automatic resolve(input logic rt, input logic rj, input logic [6:0] addr, input logic mis);
    expect_upd(addr, rt, rj, mis);
    step(1'b0, 7'h00, 1'b0, 1'b1, rt, rj);
  endtask

  task automatic do_reset();
    arst_n = 1'b1;
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b0;
  endtask

  initial begin
    push_valid = 0; push_pc = '0; push_pred = 0;
    resolve_valid = 0; resolve_taken = 0; resolve_jump = 0;

    do_reset();
    check("rst_count", int'(count), 0);
    check("rst_push_ready", int'(push_ready), 1);
    check("rst_bht_en", int'(bht_en), 0);
    check("rst_bht_addr", int'(bht_write_addr), 0);
    check("rst_mispredict", int'(mispredict), 0);
    check("rst_redirect", int'(redirect_taken), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_underflow", int'(underflow), 0);

    // Correct prediction
    push(7'h14, 1'b1);
    check("t1_count_after_push", int'(count), 1);
    resolve(1'b1, 1'b0, 7'h14, 1'b0);
    check("t1_count", int'(count), 0);

    // Mispredict flush
    push(7'h04, 1'b0);
    push(7'h08, 1'b1);
    push(7'h0C, 1'b1);
    check("t2_count_before", int'(count), 3);
    resolve(1'b1, 1'b0, 7'h04, 1'b1);
    check("t2_count_flushed", int'(count), 0);
    check("t2_underflow_clear", int'(underflow), 0);
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_underflow", int'(underflow), 1);
    do_reset();

    // Full / overflow / wrap
    for (int i = 0; i < 4; i++) push(7'(8'h10 + i), 1'b1);
    check("t3_count_full", int'(count), 4);
    check("t3_push_ready", int'(push_ready), 0);
    push(7'h7F, 1'b1);
    check("t3_overflow", int'(overflow), 1);
    check("t3_count_after_drop", int'(count), 4);
    for (int i = 0; i < 4; i++) resolve(1'b1, 1'b0, 7'(8'h10 + i), 1'b0);
    check("t3_count_drained", int'(count), 0);
    for (int i = 0; i < 4; i++) push(7'(8'h20 + i), 1'b0);
    for (int i = 0; i < 4; i++) resolve(1'b0, 1'b0, 7'(8'h20 + i), 1'b0);
    check("t3_count_drained2", int'(count), 0);
    check("t3_overflow_sticky", int'(overflow), 1);
    do_reset();

    // Simultaneous push + resolve at full
    for (int i = 0; i < 4; i++) push(7'(8'h30 + i), 1'b1);
    expect_upd(7'h30, 1'b1, 1'b0, 1'b0);
    step(1'b1, 7'h34, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_count_kept", int'(count), 4);
    check("t4_no_overflow", int'(overflow), 0);
    expect_upd(7'h31, 1'b0, 1'b0, 1'b1);
    step(1'b1, 7'h35, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_count_flush", int'(count), 0);
    check("t4_no_overflow2", int'(overflow), 0);
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t4_push_discarded", int'(underflow), 1);
    do_reset();

    // Jump mispredict, then reset colliding with a resolve
    push(7'h40, 1'b0);
    resolve(1'b0, 1'b1, 7'h40, 1'b1);
    push(7'h41, 1'b1);
    arst_n = 1'b1;
    step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_rst_bht_en", int'(bht_en), 0);
    check("t5_rst_mispredict", int'(mispredict), 0);
    check("t5_rst_count", int'(count), 0);
    arst_n = 1'b0;
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
